// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and types for the VGA timing block.
package vga_pkg;

  localparam int unsigned VGA_H_VIS = 640;
  localparam int unsigned VGA_H_FP  = 16;
  localparam int unsigned VGA_H_SW  = 96;
  localparam int unsigned VGA_H_BP  = 48;
  localparam int unsigned VGA_V_VIS = 480;
  localparam int unsigned VGA_V_FP  = 10;
  localparam int unsigned VGA_V_SW  = 2;
  localparam int unsigned VGA_V_BP  = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SW + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SW + VGA_V_BP;

  localparam int unsigned RGB_W = 3;
  localparam int unsigned CNT_W = 10;

  // Both syncs are active-low on the 640x480@60 mode.
  localparam logic SYNC_ACTIVE = 1'b0;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [RGB_W-1:0] rgb_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vo;
  } raster_t;

  function automatic logic in_window(cnt_t c, int unsigned lo, int unsigned len);
    return (32'(c) >= lo) && (32'(c) < lo + len);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register; DEPTH of 0 degenerates to a wire.
module vga_delay_line #(
  parameter int unsigned       WIDTH   = 3,
  parameter int unsigned       DEPTH   = 0,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctrl;
    always_comb unused_ctrl = ^{clk, rst, en};
    always_comb q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (en) begin
        stage[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    always_comb q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel divider, h/v counters, and latency-matched
// registered sync/colour outputs.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned DIV   = 2,
  parameter int unsigned H_VIS = VGA_H_VIS,
  parameter int unsigned H_FP  = VGA_H_FP,
  parameter int unsigned H_SW  = VGA_H_SW,
  parameter int unsigned H_BP  = VGA_H_BP,
  parameter int unsigned V_VIS = VGA_V_VIS,
  parameter int unsigned V_FP  = VGA_V_FP,
  parameter int unsigned V_SW  = VGA_V_SW,
  parameter int unsigned V_BP  = VGA_V_BP,
  parameter int unsigned LAT   = 0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] px,
  output logic [9:0] py,
  output logic       pix_tick,
  output logic       video_on,
  output logic       frame_start,
  input  logic [2:0] rgb_in,
  output logic [2:0] rgb_out,
  output logic       hsync,
  output logic       vsync
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SW + V_BP;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam cnt_t             H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t             V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam raster_t          RAW_IDLE = '{hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE, vo: 1'b0};

  logic [DIV_W-1:0] divcnt, divcnt_nxt;
  cnt_t             hcnt, vcnt;
  raster_t          raw, aligned;

  always_comb divcnt_nxt = (divcnt == DIV_LAST) ? '0 : divcnt + 1'b1;

  // pix_tick is registered from the next divider value so it equals
  // (divcnt == DIV-1) in normal running yet stays low through reset, even for DIV=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      divcnt   <= '0;
      pix_tick <= 1'b0;
    end else begin
      divcnt   <= divcnt_nxt;
      pix_tick <= (divcnt_nxt == DIV_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_tick) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  always_comb begin
    raw.hs = in_window(hcnt, H_VIS + H_FP, H_SW) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    raw.vs = in_window(vcnt, V_VIS + V_FP, V_SW) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    raw.vo = (32'(hcnt) < H_VIS) && (32'(vcnt) < V_VIS);
  end

  always_comb begin
    px          = hcnt;
    py          = vcnt;
    video_on    = raw.vo;
    frame_start = pix_tick && (hcnt == H_LAST) && (vcnt == V_LAST);
  end

  vga_delay_line #(
    .WIDTH   ($bits(raster_t)),
    .DEPTH   (LAT),
    .RST_VAL (RAW_IDLE)
  ) u_align (
    .clk (clk),
    .rst (rst),
    .en  (pix_tick),
    .d   (raw),
    .q   (aligned)
  );

  // Blanking selects a constant, so an unknown rgb_in outside the active area never reaches the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync   <= ~SYNC_ACTIVE;
      vsync   <= ~SYNC_ACTIVE;
      rgb_out <= '0;
    end else if (pix_tick) begin
      hsync   <= aligned.hs;
      vsync   <= aligned.vs;
      rgb_out <= aligned.vo ? rgb_in : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: four instances (base, LAT=2, DIV=1,
// reduced geometry) checked against an arithmetic raster model.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [3:0][9:0] px_o, py_o;
  logic [3:0]      tick_o, von_o, fs_o, hs_o, vs_o;
  logic [3:0][2:0] rgb_i, rgb_o;

  int total = 0;
  int bad   = 0;

  int k = 0;
  int n[4];
  int salt[4];

  int div_p[4] = '{2, 2, 1, 2};
  int lat_p[4] = '{0, 2, 0, 1};
  int hvis[4]  = '{640, 640, 640, 8};
  int hfp[4]   = '{16, 16, 16, 2};
  int hsw[4]   = '{96, 96, 96, 3};
  int hbp[4]   = '{48, 48, 48, 3};
  int vvis[4]  = '{480, 480, 480, 6};
  int vfp[4]   = '{10, 10, 10, 1};
  int vsw[4]   = '{2, 2, 2, 2};
  int vbp[4]   = '{33, 33, 33, 2};

  always #5 clk = ~clk;

  vga_timing #(.DIV(2), .LAT(0)) u_base (
    .clk(clk), .rst(rst), .px(px_o[0]), .py(py_o[0]), .pix_tick(tick_o[0]),
    .video_on(von_o[0]), .frame_start(fs_o[0]), .rgb_in(rgb_i[0]),
    .rgb_out(rgb_o[0]), .hsync(hs_o[0]), .vsync(vs_o[0]));

  vga_timing #(.DIV(2), .LAT(2)) u_lat (
    .clk(clk), .rst(rst), .px(px_o[1]), .py(py_o[1]), .pix_tick(tick_o[1]),
    .video_on(von_o[1]), .frame_start(fs_o[1]), .rgb_in(rgb_i[1]),
    .rgb_out(rgb_o[1]), .hsync(hs_o[1]), .vsync(vs_o[1]));

  vga_timing #(.DIV(1), .LAT(0)) u_fast (
    .clk(clk), .rst(rst), .px(px_o[2]), .py(py_o[2]), .pix_tick(tick_o[2]),
    .video_on(von_o[2]), .frame_start(fs_o[2]), .rgb_in(rgb_i[2]),
    .rgb_out(rgb_o[2]), .hsync(hs_o[2]), .vsync(vs_o[2]));

  vga_timing #(
    .DIV(2), .H_VIS(8), .H_FP(2), .H_SW(3), .H_BP(3),
    .V_VIS(6), .V_FP(1), .V_SW(2), .V_BP(2), .LAT(1)
  ) u_small (
    .clk(clk), .rst(rst), .px(px_o[3]), .py(py_o[3]), .pix_tick(tick_o[3]),
    .video_on(von_o[3]), .frame_start(fs_o[3]), .rgb_in(rgb_i[3]),
    .rgb_out(rgb_o[3]), .hsync(hs_o[3]), .vsync(vs_o[3]));

  // Reference model: n[i] = pixel ticks consumed since reset; everything
  // else is plain arithmetic on that count.
  function automatic int ht(int i); return hvis[i] + hfp[i] + hsw[i] + hbp[i]; endfunction
  function automatic int vt(int i); return vvis[i] + vfp[i] + vsw[i] + vbp[i]; endfunction
  function automatic int hpos(int i, int m); return m % ht(i); endfunction
  function automatic int vpos(int i, int m); return (m / ht(i)) % vt(i); endfunction

  function automatic logic vis(int i, int m);
    return (hpos(i, m) < hvis[i]) && (vpos(i, m) < vvis[i]);
  endfunction

  function automatic logic [2:0] col(int i, int m);
    if (i == 0) return 3'b111;
    return 3'((hpos(i, m) * 5 + vpos(i, m) * 3 + salt[i]) % 8);
  endfunction

  function automatic logic hs_exp(int i, int m);
    int h;
    if (m < 0) return 1'b1;
    h = hpos(i, m);
    return !((h >= hvis[i] + hfp[i]) && (h < hvis[i] + hfp[i] + hsw[i]));
  endfunction

  function automatic logic vs_exp(int i, int m);
    int v;
    if (m < 0) return 1'b1;
    v = vpos(i, m);
    return !((v >= vvis[i] + vfp[i]) && (v < vvis[i] + vfp[i] + vsw[i]));
  endfunction

  function automatic logic [2:0] rgb_exp(int i, int m);
    if (m < 0 || !vis(i, m)) return 3'b000;
    return col(i, m);
  endfunction

  function automatic logic tick_exp(int i);
    return (k >= 1) && ((k % div_p[i]) == div_p[i] - 1);
  endfunction

  function automatic logic fs_exp(int i);
    return tick_exp(i) && ((n[i] % (ht(i) * vt(i))) == ht(i) * vt(i) - 1);
  endfunction

  // Raster index whose state is currently visible on the registered pins.
  function automatic int pin(int i); return n[i] - 1 - lat_p[i]; endfunction

  task automatic step();
    @(posedge clk);
    if (rst) begin
      k = 0;
      for (int i = 0; i < 4; i++) n[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) if (tick_exp(i)) n[i]++;
      k++;
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      int q;
      q = n[i] - lat_p[i];
      rgb_i[i] = (q >= 0 && vis(i, q)) ? col(i, q) : 3'bxxx;
    end
  endtask

  task automatic test_reset();
    int cycles;
    int first_tick;
    int prev_tick;
    cycles = 2 + int'($urandom_range(0, 3));
    first_tick = -1;
    prev_tick = -1;
    rst = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        total++;
        if (px_o[i] !== 10'd0 || py_o[i] !== 10'd0 || hs_o[i] !== 1'b1 || vs_o[i] !== 1'b1 ||
            rgb_o[i] !== 3'd0 || tick_o[i] !== 1'b0 || fs_o[i] !== 1'b0) begin
          bad++;
          $display("FAIL reset_state inst%0d: px=%0d py=%0d hs=%b vs=%b rgb=%0d tick=%b fs=%b, want 0 0 1 1 0 0 0",
                   i, px_o[i], py_o[i], hs_o[i], vs_o[i], rgb_o[i], tick_o[i], fs_o[i]);
        end
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        total++;
        if (tick_o[i] !== tick_exp(i)) begin
          bad++;
          $display("FAIL reset_tick inst%0d k=%0d: got %b want %b", i, k, tick_o[i], tick_exp(i));
        end
      end
      if (tick_o[0] === 1'b1) begin
        if (first_tick < 0) first_tick = k;
        if (prev_tick >= 0) begin
          total++;
          if (k - prev_tick != 2) begin
            bad++;
            $display("FAIL tick_period k=%0d: got %0d clk want 2", k, k - prev_tick);
          end
        end
        prev_tick = k;
      end
    end
    total++;
    if (first_tick != div_p[0] - 1) begin
      bad++;
      $display("FAIL first_tick: got clk %0d after release want %0d", first_tick, div_p[0] - 1);
    end
  endtask

  task automatic test_line();
    int hs_fall[$];
    int hs_low = -1, px_fall = -1, rgb_rise = -1, rgb_fall = -1, rgb_rise2 = -1;
    logic ph, pr;
    ph = hs_o[0];
    pr = (rgb_o[0] != 3'd0);
    for (int c = 0; c < 3300; c++) begin
      step();
      total++;
      if (px_o[0] !== 10'(hpos(0, n[0])) || py_o[0] !== 10'(vpos(0, n[0]))) begin
        bad++;
        $display("FAIL line_counter k=%0d: got (%0d,%0d) want (%0d,%0d)", k, px_o[0], py_o[0],
                 hpos(0, n[0]), vpos(0, n[0]));
      end
      total++;
      if (von_o[0] !== vis(0, n[0])) begin
        bad++;
        $display("FAIL line_video_on k=%0d: got %b want %b", k, von_o[0], vis(0, n[0]));
      end
      total++;
      if (hs_o[0] !== hs_exp(0, pin(0)) || rgb_o[0] !== rgb_exp(0, pin(0))) begin
        bad++;
        $display("FAIL line_pins k=%0d: got hs=%b rgb=%0d want hs=%b rgb=%0d", k, hs_o[0], rgb_o[0],
                 hs_exp(0, pin(0)), rgb_exp(0, pin(0)));
      end
      if (ph && !hs_o[0]) begin
        hs_fall.push_back(k);
        if (px_fall < 0) px_fall = int'(px_o[0]);
      end
      if (!ph && hs_o[0] && hs_fall.size() > 0 && hs_low < 0) hs_low = k - hs_fall[0];
      if (!pr && rgb_o[0] != 3'd0) begin
        if (rgb_rise < 0) rgb_rise = k;
        else if (rgb_fall >= 0 && rgb_rise2 < 0) rgb_rise2 = k;
      end
      if (pr && rgb_o[0] == 3'd0 && rgb_rise >= 0 && rgb_fall < 0) rgb_fall = k;
      ph = hs_o[0];
      pr = (rgb_o[0] != 3'd0);
    end
    total++;
    if (rgb_rise < 0 || rgb_fall - rgb_rise != 1280) begin
      bad++;
      $display("FAIL line_visible: got %0d clk of colour want 1280", rgb_fall - rgb_rise);
    end
    total++;
    if (rgb_rise2 < 0 || rgb_rise2 - rgb_fall != 320) begin
      bad++;
      $display("FAIL line_blank: got %0d clk of blank want 320", rgb_rise2 - rgb_fall);
    end
    total++;
    if (hs_low != 192) begin
      bad++;
      $display("FAIL hsync_width: got %0d clk want 192", hs_low);
    end
    total++;
    if (hs_fall.size() < 2 || hs_fall[1] - hs_fall[0] != 1600) begin
      bad++;
      $display("FAIL line_period: got %0d falls, spacing wrong (want 1600 clk)", hs_fall.size());
    end
    total++;
    if (px_fall != 657) begin
      bad++;
      $display("FAIL hsync_phase: px at fall got %0d want 657", px_fall);
    end
  endtask

  task automatic test_lat2();
    int fall0 = -1, fall1 = -1, px_fall1 = -1;
    logic p0, p1;
    p0 = hs_o[0];
    p1 = hs_o[1];
    for (int c = 0; c < 1700; c++) begin
      step();
      total++;
      if (hs_o[1] !== hs_exp(1, pin(1)) || vs_o[1] !== vs_exp(1, pin(1)) ||
          rgb_o[1] !== rgb_exp(1, pin(1))) begin
        bad++;
        $display("FAIL lat2_pins k=%0d: got hs=%b vs=%b rgb=%0d want hs=%b vs=%b rgb=%0d", k,
                 hs_o[1], vs_o[1], rgb_o[1], hs_exp(1, pin(1)), vs_exp(1, pin(1)), rgb_exp(1, pin(1)));
      end
      if (p0 && !hs_o[0] && fall0 < 0) fall0 = k;
      if (p1 && !hs_o[1] && fall0 >= 0 && fall1 < 0) begin
        fall1 = k;
        px_fall1 = int'(px_o[1]);
      end
      p0 = hs_o[0];
      p1 = hs_o[1];
    end
    total++;
    if (fall0 < 0 || fall1 - fall0 != 4) begin
      bad++;
      $display("FAIL lat2_shift: got %0d clk later want 4", fall1 - fall0);
    end
    total++;
    if (px_fall1 != 659) begin
      bad++;
      $display("FAIL lat2_phase: px at fall got %0d want 659", px_fall1);
    end
  endtask

  task automatic test_frame();
    int fs_at[$];
    int vs_fall = -1, vs_low = -1, px_vf = -1, py_vf = -1;
    logic pv, after_fs;
    pv = vs_o[3];
    after_fs = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      step();
      if (after_fs) begin
        total++;
        if (px_o[3] !== 10'd0 || py_o[3] !== 10'd0) begin
          bad++;
          $display("FAIL frame_wrap k=%0d: got (%0d,%0d) want (0,0)", k, px_o[3], py_o[3]);
        end
      end
      total++;
      if (fs_o[3] !== fs_exp(3) || px_o[3] !== 10'(hpos(3, n[3])) || py_o[3] !== 10'(vpos(3, n[3])) ||
          vs_o[3] !== vs_exp(3, pin(3)) || hs_o[3] !== hs_exp(3, pin(3))) begin
        bad++;
        $display("FAIL frame_model k=%0d: got fs=%b px=%0d py=%0d vs=%b hs=%b want fs=%b px=%0d py=%0d vs=%b hs=%b",
                 k, fs_o[3], px_o[3], py_o[3], vs_o[3], hs_o[3], fs_exp(3), hpos(3, n[3]),
                 vpos(3, n[3]), vs_exp(3, pin(3)), hs_exp(3, pin(3)));
      end
      after_fs = fs_o[3];
      if (fs_o[3] === 1'b1) fs_at.push_back(k);
      if (pv && !vs_o[3] && vs_fall < 0) begin
        vs_fall = k;
        px_vf = int'(px_o[3]);
        py_vf = int'(py_o[3]);
      end
      if (!pv && vs_o[3] && vs_fall >= 0 && vs_low < 0) vs_low = k - vs_fall;
      pv = vs_o[3];
    end
    total++;
    if (fs_at.size() < 3) begin
      bad++;
      $display("FAIL frame_count: got %0d pulses want at least 3", fs_at.size());
    end
    for (int j = 1; j < fs_at.size(); j++) begin
      total++;
      if (fs_at[j] - fs_at[j-1] != 352) begin
        bad++;
        $display("FAIL frame_period: got %0d clk want 352", fs_at[j] - fs_at[j-1]);
      end
    end
    total++;
    if (vs_low != 64) begin
      bad++;
      $display("FAIL vsync_width: got %0d clk want 64", vs_low);
    end
    total++;
    if (px_vf != 2 || py_vf != 7) begin
      bad++;
      $display("FAIL vsync_phase: got (%0d,%0d) want (2,7)", px_vf, py_vf);
    end
  endtask

  task automatic test_div1();
    int falls[$];
    logic ph;
    ph = hs_o[2];
    for (int c = 0; c < 1700; c++) begin
      step();
      total++;
      if (tick_o[2] !== 1'b1) begin
        bad++;
        $display("FAIL div1_tick k=%0d: got %b want 1", k, tick_o[2]);
      end
      total++;
      if ($isunknown(rgb_o[2]) || rgb_o[2] !== rgb_exp(2, pin(2)) || hs_o[2] !== hs_exp(2, pin(2))) begin
        bad++;
        $display("FAIL div1_pins k=%0d: got rgb=%b hs=%b want rgb=%b hs=%b", k, rgb_o[2], hs_o[2],
                 rgb_exp(2, pin(2)), hs_exp(2, pin(2)));
      end
      if (ph && !hs_o[2]) falls.push_back(k);
      ph = hs_o[2];
    end
    total++;
    if (falls.size() < 2 || falls[1] - falls[0] != 800) begin
      bad++;
      $display("FAIL div1_line_period: got %0d falls, spacing wrong (want 800 clk)", falls.size());
    end
  endtask

  task automatic test_mid_reset();
    int tx, ty;
    logic found;
    tx = int'($urandom_range(1, 15));
    ty = int'($urandom_range(1, 10));
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      step();
      if (int'(px_o[3]) == tx && int'(py_o[3]) == ty) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL midrst_wait: position (%0d,%0d) not reached within 400 clk", tx, ty);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (px_o[i] !== 10'd0 || py_o[i] !== 10'd0 || hs_o[i] !== 1'b1 || vs_o[i] !== 1'b1 ||
          rgb_o[i] !== 3'd0 || tick_o[i] !== 1'b0 || fs_o[i] !== 1'b0) begin
        bad++;
        $display("FAIL midrst_state inst%0d: px=%0d py=%0d hs=%b vs=%b rgb=%0d tick=%b fs=%b, want 0 0 1 1 0 0 0",
                 i, px_o[i], py_o[i], hs_o[i], vs_o[i], rgb_o[i], tick_o[i], fs_o[i]);
      end
    end
    for (int c = 0; c < 1000; c++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        total++;
        if (px_o[i] !== 10'(hpos(i, n[i])) || py_o[i] !== 10'(vpos(i, n[i])) ||
            tick_o[i] !== tick_exp(i) || von_o[i] !== vis(i, n[i]) || fs_o[i] !== fs_exp(i) ||
            hs_o[i] !== hs_exp(i, pin(i)) || vs_o[i] !== vs_exp(i, pin(i)) ||
            rgb_o[i] !== rgb_exp(i, pin(i))) begin
          bad++;
          $display("FAIL midrst_restart inst%0d k=%0d: got px=%0d py=%0d tick=%b hs=%b rgb=%0d want px=%0d py=%0d tick=%b hs=%b rgb=%0d",
                   i, k, px_o[i], py_o[i], tick_o[i], hs_o[i], rgb_o[i], hpos(i, n[i]),
                   vpos(i, n[i]), tick_exp(i), hs_exp(i, pin(i)), rgb_exp(i, pin(i)));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      n[i] = 0;
      salt[i] = int'($urandom_range(0, 7));
      rgb_i[i] = 3'bxxx;
    end
    test_reset();
    test_line();
    test_lat2();
    test_frame();
    test_div1();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
